cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter and broadcast register for the Common Data Bus (CDB). It sits between the execution units (ALU1, ALU2, and optionally the LSU) and the CDB consumers (ROB, reservation stations, register status). Each cycle it grants the bus to at most one requesting unit and registers the winner's tag and result for broadcast on the following cycle. The round-robin policy guarantees bounded wait for every requester.

## Interface
Parameters:
- NUM_REQ, 3, number of requesting units; legal range 2..8; index 0 = ALU1, 1 = ALU2, 2 = LSU.
- TAG_W, 6, width of the physical-register tag.
- DATA_W, 32, width of the result data.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req_valid  in  NUM_REQ  bit i = unit i requests the CDB; held high until granted.
- req_tag  in  NUM_REQ*TAG_W  unit i tag in bits [i*TAG_W +: TAG_W].
- req_data  in  NUM_REQ*DATA_W  unit i result in bits [i*DATA_W +: DATA_W].
- cdb_stall  in  1  downstream cannot accept a broadcast this cycle; no grant is issued.
- flush  in  1  pipeline squash; no grant is issued and the pending broadcast is dropped.
- grant  out  NUM_REQ  one-hot or zero; combinational and valid in the same cycle as the request.
- cdb_valid  out  1  broadcast valid (registered).
- cdb_tag  out  TAG_W  broadcast tag (registered).
- cdb_data  out  DATA_W  broadcast data (registered).
- cdb_src  out  $clog2(NUM_REQ)  index of the unit that produced the broadcast (registered).

## Operation
- State consists of rr_ptr (index of the highest-priority requester) and the broadcast registers.
- Candidate search: scan indices rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ. The first i with req_valid[i]=1 wins.
- grant[winner] = 1 only when all of the following hold: at least one request is present, cdb_stall=0, flush=0, and rst=0. Otherwise grant = 0.
- On a grant edge:
  - cdb_valid ← 1.
  - cdb_tag ← req_tag slice of the winner.
  - cdb_data ← req_data slice of the winner.
  - cdb_src ← winner index.
  - rr_ptr ← (winner+1) mod NUM_REQ. For non-power-of-2 NUM_REQ, the wrap is an explicit compare, not a bit truncation.
- On an edge with no grant: cdb_valid ← 0. cdb_tag, cdb_data, and cdb_src hold their previous values. rr_ptr holds.
- flush on an edge: cdb_valid ← 0 and rr_ptr holds. Requests present during the flush cycle are not granted.
- cdb_stall does not clear a cdb_valid already registered. That broadcast completes its single cycle; only new grants are blocked.
- Requester contract: a requester drops req_valid on the edge after it sees grant and re-requests no earlier than that edge. The arbiter does not detect or filter a second grant to a requester that violates this contract.
- Reset (rst=1 at an edge):
  - rr_ptr ← 0.
  - cdb_valid ← 0, cdb_tag ← 0, cdb_data ← 0, cdb_src ← 0.
  - grant is forced to 0 combinationally while rst=1.
  - Reset mid-broadcast discards the broadcast; the requester must re-request after reset.

## Timing
- Grant latency: 0 cycles. A request raised in cycle t can be granted in cycle t.
- Broadcast latency: 1 cycle. A grant in cycle t produces cdb_valid=1 in cycle t+1 for exactly one cycle.
- Throughput: one broadcast per cycle; back-to-back grants to different units are allowed.
- Starvation bound: a continuously requesting unit is granted within NUM_REQ stall-free, flush-free cycles.
- Simultaneous flush and cdb_stall: flush takes priority, so cdb_valid clears.
- All outputs except grant are registered. grant depends combinationally on req_valid, rr_ptr, cdb_stall, flush, and rst.

## Test plan
- Reset check: hold rst=1 for 2 cycles with req_valid=3'b111. Required: grant=0 throughout. After release: cdb_valid=0, cdb_tag=0, cdb_data=0, rr_ptr=0.
- Single requester: req_valid=3'b010, tag 6'h15, data 32'hDEADBEEF in cycle t. Required: grant=3'b010 in cycle t. In cycle t+1: cdb_valid=1, tag 6'h15, data 32'hDEADBEEF, cdb_src=1. cdb_valid=0 in t+2.
- Round-robin rotation: all three units request continuously and re-request one cycle after each grant. Required grant order: 0,1,2,0,1,2. No unit waits more than 3 cycles.
- Stall: cdb_stall=1 for 3 cycles while req_valid=3'b101. Required: grant=0 and cdb_valid=0 during the stall. When the stall releases, unit 0 is granted first (rr_ptr=0), then unit 2.
- Flush: grant to unit 1 in cycle t, flush=1 in cycle t+1 with req_valid=3'b001. Required: cdb_valid=1 in t+1 for unit 1 (the broadcast completes). No grant in t+1. cdb_valid=0 in t+2. Unit 0 is granted in t+2 once flush=0.
- Mid-broadcast reset: grant in cycle t, rst=1 at the end of cycle t. Required: cdb_valid=0 in cycle t+1 and rr_ptr returns to 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the Common Data Bus with a one-cycle registered broadcast.
// grant_o is combinational; cdb_*_o follow one edge after a grant.
module cdb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32,
  localparam int SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic                      cdb_stall_i,
  input  logic                      flush_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      cdb_valid_o,
  output logic [TAG_W-1:0]          cdb_tag_o,
  output logic [DATA_W-1:0]         cdb_data_o,
  output logic [SRC_W-1:0]          cdb_src_o
);

  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

  logic              found;
  logic              grant_vld;
  logic [SRC_W-1:0]  winner;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;
  int                j;

  // Scan from rr_ptr upward with an explicit wrap so non-power-of-2 NUM_REQ is handled.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_tag  = '0;
    win_data = '0;
    j        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_valid_i[j]) begin
        found    = 1'b1;
        winner   = SRC_W'(j);
        win_tag  = req_tag_i[j*TAG_W +: TAG_W];
        win_data = req_data_i[j*DATA_W +: DATA_W];
      end
    end
  end

  assign grant_vld = found & ~cdb_stall_i & ~flush_i & ~rst_i;
  assign grant_o   = grant_vld ? (NUM_REQ'(1) << winner) : '0;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    cdb_tag_d  = cdb_tag_q;
    cdb_data_d = cdb_data_q;
    cdb_src_d  = cdb_src_q;
    if (grant_vld) begin
      rr_ptr_d   = (winner == SRC_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      cdb_tag_d  = win_tag;
      cdb_data_d = win_data;
      cdb_src_d  = winner;
    end
  end

  // Without a grant the payload holds; only the valid bit drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= grant_vld;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid_o = cdb_valid_q;
  assign cdb_tag_o   = cdb_tag_q;
  assign cdb_data_o  = cdb_data_q;
  assign cdb_src_o   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus a randomized requester population,
// all checked against a cycle-level reference of the round-robin rules.
module tb_cdb_arbiter;
  localparam int N  = 3;
  localparam int TW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, stall, flush;
  logic [N-1:0]      rv;
  logic [N*TW-1:0]   rt;
  logic [N*DW-1:0]   rd;
  logic [N-1:0]      grant;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_data;
  logic [1:0]        cdb_src;

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv), .req_tag_i(rt), .req_data_i(rd),
    .cdb_stall_i(stall), .flush_i(flush), .grant_o(grant),
    .cdb_valid_o(cdb_valid), .cdb_tag_o(cdb_tag), .cdb_data_o(cdb_data), .cdb_src_o(cdb_src)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference state: priority pointer and the broadcast registers.
  int            m_ptr  = 0;
  bit            m_vld  = 0;
  logic [TW-1:0] m_tag  = '0;
  logic [DW-1:0] m_data = '0;
  int            m_src  = 0;

  function automatic int ref_winner();
    if (rst || stall || flush) return -1;
    for (int k = 0; k < N; k++)
      if (rv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // Checks grant mid-cycle, advances the reference at the edge, then checks the broadcast.
  task automatic tick(output int w);
    #4;
    w = ref_winner();
    chk("grant", grant, (w < 0) ? 0 : (1 << w));
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_vld = 0; m_tag = '0; m_data = '0; m_src = 0;
    end else if (w >= 0) begin
      m_vld = 1; m_tag = rt[w*TW +: TW]; m_data = rd[w*DW +: DW]; m_src = w;
      m_ptr = (w + 1) % N;
    end else begin
      m_vld = 0;
    end
    #1;
    chk("cdb_valid", cdb_valid, m_vld);
    chk("cdb_tag", cdb_tag, m_tag);
    chk("cdb_data", cdb_data, m_data);
    chk("cdb_src", cdb_src, m_src);
  endtask

  task automatic drive(input logic [N-1:0] v, input bit s, input bit f, input bit r);
    rv = v; stall = s; flush = f; rst = r;
  endtask

  int w;
  int seq[6];
  int exp_seq[6] = '{0, 1, 2, 0, 1, 2};
  bit pend[N];
  bit just_g[N];
  int waitc[N];

  initial begin
    rt = {$urandom, $urandom};
    rd = {$urandom, $urandom, $urandom};

    // Reset with all units requesting: no grant, everything cleared.
    drive(3'b111, 0, 0, 1);
    tick(w); tick(w);
    chk("rst_grant_none", w, -1);
    drive(3'b000, 0, 0, 0);
    tick(w);
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_cdb_tag", cdb_tag, 0);

    // Lone requester on unit 1.
    rt[1*TW +: TW] = 6'h15;
    rd[1*DW +: DW] = 32'hDEADBEEF;
    drive(3'b010, 0, 0, 0);
    tick(w);
    chk("single_tag", cdb_tag, 6'h15);
    chk("single_data", cdb_data, 32'hDEADBEEF);
    chk("single_src", cdb_src, 1);
    drive(3'b000, 0, 0, 0);
    tick(w);
    chk("single_valid_drop", cdb_valid, 0);

    // Rotation: a granted unit drops for one cycle and then re-requests.
    drive(3'b000, 0, 0, 1); tick(w);
    for (int i = 0; i < N; i++) just_g[i] = 0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) rv[i] = !just_g[i];
      rst = 0;
      tick(w);
      seq[c] = w;
      for (int i = 0; i < N; i++) just_g[i] = (i == w);
    end
    for (int c = 0; c < 6; c++) chk("rr_order", seq[c], exp_seq[c]);

    // Stall holds off grants; pointer at 0 means unit 0 goes first, then unit 2.
    drive(3'b000, 0, 0, 1); tick(w);
    for (int c = 0; c < 3; c++) begin
      drive(3'b101, 1, 0, 0);
      tick(w);
      chk("stall_valid", cdb_valid, 0);
    end
    drive(3'b101, 0, 0, 0); tick(w);
    chk("stall_first", w, 0);
    drive(3'b100, 0, 0, 0); tick(w);
    chk("stall_second", w, 2);

    // Flush the cycle after a grant: that broadcast still completes, no new grant.
    drive(3'b000, 0, 0, 1); tick(w);
    drive(3'b010, 0, 0, 0); tick(w);
    chk("flush_pre_valid", cdb_valid, 1);
    drive(3'b001, 0, 1, 0); tick(w);
    chk("flush_no_grant", w, -1);
    chk("flush_valid_clear", cdb_valid, 0);
    drive(3'b001, 0, 0, 0); tick(w);
    chk("flush_after", w, 0);

    // Reset during a broadcast discards it and sends the pointer back to 0.
    drive(3'b010, 0, 0, 0); tick(w);
    drive(3'b000, 0, 0, 1); tick(w);
    chk("midrst_valid", cdb_valid, 0);
    drive(3'b111, 0, 0, 0); tick(w);
    chk("midrst_ptr0", w, 0);

    // Randomized population obeying the requester contract.
    for (int i = 0; i < N; i++) begin pend[i] = 0; just_g[i] = 0; waitc[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (just_g[i]) pend[i] = 0;
        else if (!pend[i] && ($urandom % 2 == 0)) begin
          pend[i] = 1;
          rt[i*TW +: TW] = TW'($urandom);
          rd[i*DW +: DW] = $urandom;
        end
        rv[i] = pend[i];
      end
      stall = ($urandom % 8 == 0);
      flush = ($urandom % 16 == 0);
      rst   = ($urandom % 128 == 0);
      tick(w);
      for (int i = 0; i < N; i++) begin
        just_g[i] = (i == w);
        if (i == w) begin
          chk("starve_bound", waitc[i] < N, 1);
          waitc[i] = 0;
        end else if (rst) waitc[i] = 0;
        else if (rv[i] && !stall && !flush) waitc[i]++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
